energy_level: RTL and testbench

ENERGY_LEVEL -- requirements
Module: energy_level

---
 rtl/energy_level.sv | 106 ++++++++++
 tb/tb_energy_level.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/energy_level.sv
`default_nettype none
// ============================================================================
// energy_level : prescaled saturating energy counter with hysteretic mood FSM
// Rev 1.0
// ============================================================================
module energy_level #(
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 4,
  parameter int RESET_LEVEL = 128,
  parameter int LOW_TH      = 64,
  parameter int HIGH_TH     = 192,
  parameter int HYST        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             energy_inc,
  input  logic             energy_dec,
  output logic [WIDTH-1:0] energy,
  output logic [1:0]       state,
  output logic             state_changed,
  output logic             at_min,
  output logic             at_max
);

  localparam int               c_pw         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pw-1:0]  c_presc_last = c_pw'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] c_max        = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_reset_lvl  = WIDTH'(RESET_LEVEL);

  // Thresholds are compared against a zero-extended level so that no
  // threshold value can be silently truncated into the energy width.
  localparam logic [WIDTH:0]   c_low_enter  = (WIDTH+1)'(LOW_TH);
  localparam logic [WIDTH:0]   c_low_exit   = (WIDTH+1)'(LOW_TH + HYST);
  localparam logic [WIDTH:0]   c_high_enter = (WIDTH+1)'(HIGH_TH);
  localparam logic [WIDTH:0]   c_high_exit  = (WIDTH+1)'(HIGH_TH - HYST);

  localparam logic [1:0] c_st_low    = 2'b00;
  localparam logic [1:0] c_st_normal = 2'b01;
  localparam logic [1:0] c_st_high   = 2'b10;

  logic [c_pw-1:0]  r_presc;
  logic             w_step;
  logic [WIDTH-1:0] w_energy_nxt;
  logic [WIDTH:0]   w_level;
  logic [1:0]       w_state_nxt;
  logic             w_changed_nxt;

  assign w_step  = (r_presc == c_presc_last);
  assign w_level = {1'b0, energy};

  always_comb begin
    w_energy_nxt = energy;
    if (w_step) begin
      if (energy_inc && !energy_dec && (energy != c_max)) begin
        w_energy_nxt = energy + WIDTH'(1);
      end else if (energy_dec && !energy_inc && (energy != '0)) begin
        w_energy_nxt = energy - WIDTH'(1);
      end
    end
  end

  // Flags are derived from the next energy so they move together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      energy  <= c_reset_lvl;
      at_min  <= 1'b0;
      at_max  <= 1'b0;
    end else begin
      r_presc <= w_step ? '0 : r_presc + c_pw'(1);
      energy  <= w_energy_nxt;
      at_min  <= (w_energy_nxt == '0);
      at_max  <= (w_energy_nxt == c_max);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= c_st_normal;
      state_changed <= 1'b0;
    end else begin
      state         <= w_state_nxt;
      state_changed <= w_changed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = state;
    case (state)
      c_st_low:    if (w_level >= c_low_exit) w_state_nxt = c_st_normal;
      c_st_normal: begin
        if (w_level < c_low_enter)       w_state_nxt = c_st_low;
        else if (w_level > c_high_enter) w_state_nxt = c_st_high;
      end
      c_st_high:   if (w_level <= c_high_exit) w_state_nxt = c_st_normal;
      default:     w_state_nxt = c_st_normal;
    endcase
  end

  // Recovery from the unused encoding is silent: no pulse.
  always_comb begin
    w_changed_nxt = (state != 2'b11) && (w_state_nxt != state);
  end

endmodule
`default_nettype wire

// File: tb/tb_energy_level.sv
`default_nettype none
// Testbench for energy_level: directed scenarios plus random traffic vs. a model.
module tb_energy_level;

  localparam int P       = 4;
  localparam int MAXV    = 255;
  localparam int RST_LVL = 128;
  localparam int LOW_TH  = 64;
  localparam int HIGH_TH = 192;
  localparam int HYST    = 8;
  localparam int M_LOW = 0, M_NORMAL = 1, M_HIGH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       energy_inc = 1'b0;
  logic       energy_dec = 1'b0;
  logic [7:0] energy;
  logic [1:0] state;
  logic       state_changed;
  logic       at_min;
  logic       at_max;

  int n_tests = 0;
  int n_fail  = 0;

  int m_energy, m_mood, m_k;
  bit m_pulse, m_min, m_max;

  energy_level dut (
    .clk(clk), .rst(rst), .energy_inc(energy_inc), .energy_dec(energy_dec),
    .energy(energy), .state(state), .state_changed(state_changed),
    .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge, in terms of moods and clamped arithmetic.
  task automatic model_edge();
    int old_e, nm;
    old_e = m_energy;
    if (rst) begin
      m_energy = RST_LVL; m_mood = M_NORMAL; m_pulse = 0; m_k = 0;
      m_min = 0; m_max = 0;
    end else begin
      nm = m_mood;
      if (m_mood == M_LOW && old_e >= LOW_TH + HYST) nm = M_NORMAL;
      else if (m_mood == M_HIGH && old_e <= HIGH_TH - HYST) nm = M_NORMAL;
      else if (m_mood == M_NORMAL && old_e < LOW_TH) nm = M_LOW;
      else if (m_mood == M_NORMAL && old_e > HIGH_TH) nm = M_HIGH;
      m_pulse = (nm != m_mood);
      m_mood  = nm;
      if ((m_k % P) == P - 1 && energy_inc != energy_dec) begin
        m_energy = old_e + (energy_inc ? 1 : -1);
        if (m_energy < 0) m_energy = 0;
        if (m_energy > MAXV) m_energy = MAXV;
      end
      m_k++;
      m_min = (m_energy == 0);
      m_max = (m_energy == MAXV);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("energy", energy, m_energy);
    check("state", state, m_mood);
    check("state_changed", state_changed, m_pulse);
    check("at_min", at_min, m_min);
    check("at_max", at_max, m_max);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_until(input int target, input bit inc, input bit dec);
    int n;
    n = 0;
    energy_inc = inc; energy_dec = dec;
    while (m_energy != target && n < 5000) begin
      tick();
      n++;
    end
    energy_inc = 0; energy_dec = 0;
    check("reach_target", energy, target);
  endtask

  initial begin
    int e0, pulses;

    // Reset for two clocks, then release
    rst = 1; ticks(2);
    rst = 0;
    check("rst_energy", energy, 128);
    check("rst_state", state, 1);
    check("rst_pulse", state_changed, 0);
    check("rst_min", at_min, 0);
    check("rst_max", at_max, 0);

    // Sustained raise
    energy_inc = 1;
    ticks(4);
    check("raise_4", energy, 129);
    ticks(256);
    check("raise_260", energy, 193);
    check("raise_260_state", state, 1);
    tick();
    check("high_state", state, 2);
    check("high_pulse", state_changed, 1);
    tick();
    check("high_pulse_gone", state_changed, 0);

    // Saturation high
    ticks(600);
    check("sat_energy", energy, 255);
    check("sat_max", at_max, 1);
    energy_inc = 0; energy_dec = 1;
    ticks(4);
    check("unsat_energy", energy, 254);
    check("unsat_max", at_max, 0);

    // Hysteresis leaving HIGH
    drive_until(185, 0, 1);
    tick();
    check("hyst_185_state", state, 2);
    drive_until(184, 0, 1);
    tick();
    check("hyst_184_state", state, 1);
    check("hyst_184_pulse", state_changed, 1);

    // Hysteresis leaving LOW
    drive_until(63, 0, 1);
    tick();
    check("low_63_state", state, 0);
    drive_until(71, 1, 0);
    ticks(2);
    check("low_71_state", state, 0);
    drive_until(72, 1, 0);
    tick();
    check("low_72_state", state, 1);

    // Simultaneous requests
    e0 = energy; pulses = 0;
    energy_inc = 1; energy_dec = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state_changed) pulses++;
    end
    energy_inc = 0; energy_dec = 0;
    check("both_energy", energy, e0);
    check("both_pulses", pulses, 0);

    // Single-cycle request on a non-step cycle
    while ((m_k % P) != 0) tick();
    energy_inc = 1; tick(); energy_inc = 0;
    ticks(6);
    check("nonstep_energy", energy, e0);

    // Reset in a step cycle while LOW at 50
    drive_until(50, 0, 1);
    ticks(2);
    check("pre_rst_state", state, 0);
    while ((m_k % P) != P - 1) tick();
    energy_dec = 1; rst = 1;
    tick();
    rst = 0; energy_dec = 0;
    check("midrst_energy", energy, 128);
    check("midrst_state", state, 1);
    check("midrst_pulse", state_changed, 0);

    // Saturation low
    energy_dec = 1;
    ticks(600);
    energy_dec = 0;
    check("sat_low_energy", energy, 0);
    check("sat_low_min", at_min, 1);

    // Random traffic with biased phases and occasional reset
    for (int ph = 0; ph < 20; ph++) begin
      int bias;
      bias = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        energy_inc = ($urandom_range(0, 99) < bias);
        energy_dec = ($urandom_range(0, 99) >= bias);
        if ($urandom_range(0, 15) == 0) begin
          energy_inc = $urandom_range(0, 1);
          energy_dec = energy_inc;
        end
        rst = ($urandom_range(0, 499) == 0);
        tick();
      end
    end
    rst = 0; energy_inc = 0; energy_dec = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
